// File: rtl/snn_egress_pkg.sv
// Shared definitions for the SNN spike egress packer.
// Holds the stream word layout, the tkeep constant, the buffered
// payload struct and the word-build helpers for spikes and markers.
package snn_egress_pkg;

  localparam int unsigned AXIS_W      = 32;
  localparam int unsigned MARKER_BIT  = 31;
  localparam int unsigned TS_LSB      = 16;
  localparam int unsigned TS_MSB      = 30;
  localparam int unsigned NID_MSB     = 15;
  localparam int unsigned TS_FIELD_W  = TS_MSB - TS_LSB + 1;
  localparam int unsigned LOW_FIELD_W = NID_MSB + 1;

  localparam logic [3:0] TKEEP_ALL = 4'hF;

  // One buffered egress entry: stream word plus its tlast flag.
  typedef struct packed {
    logic              tlast;
    logic [AXIS_W-1:0] tdata;
  } egress_word_t;

  // Spike word: marker bit clear, timestep, zero-extended neuron id.
  function automatic logic [AXIS_W-1:0] build_spike(
    input logic [TS_FIELD_W-1:0]  ts,
    input logic [LOW_FIELD_W-1:0] nid
  );
    logic [AXIS_W-1:0] w;
    w                 = '0;
    w[MARKER_BIT]     = 1'b0;
    w[TS_MSB:TS_LSB]  = ts;
    w[NID_MSB:0]      = nid;
    return w;
  endfunction

  // Marker word: marker bit set, timestep being closed, low payload.
  function automatic logic [AXIS_W-1:0] build_marker(
    input logic [TS_FIELD_W-1:0]  ts,
    input logic [LOW_FIELD_W-1:0] low
  );
    logic [AXIS_W-1:0] w;
    w                 = '0;
    w[MARKER_BIT]     = 1'b1;
    w[TS_MSB:TS_LSB]  = ts;
    w[NID_MSB:0]      = low;
    return w;
  endfunction

endpackage

// File: rtl/snn_egress_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   push_i, wdata_i    write request and data (ignored when full, unless popping)
//   pop_i              consume the head entry (ignored when empty)
//   rdata_o, valid_o   registered head entry and its valid flag
//   full_o             no free entry this cycle
//   level_o            registered occupancy, 0..DEPTH
module snn_egress_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             do_push_c, do_pop_c;

  // Pointer/level update and next head selection.
  always_comb begin
    do_pop_c  = pop_i && (level_q != '0);
    do_push_c = push_i && ((level_q != LVL_W'(DEPTH)) || do_pop_c);
    wr_ptr_d  = wr_ptr_q + PTR_W'(do_push_c);
    rd_ptr_d  = rd_ptr_q + PTR_W'(do_pop_c);
    level_d   = level_q + LVL_W'(do_push_c) - LVL_W'(do_pop_c);
    valid_d   = (level_d != '0);
    // The new head is the incoming word when it lands in the slot the
    // read pointer moves to; otherwise it is already in storage.
    if (do_push_c && (wr_ptr_q == rd_ptr_d)) begin
      head_d = wdata_i;
    end else if (level_d != '0) begin
      head_d = mem_q[rd_ptr_d];
    end else begin
      head_d = head_q;
    end
  end

  // Storage array, no reset needed: entries are only read after a write.
  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Control and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign rdata_o = head_q;
  assign valid_o = valid_q;
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign level_o = level_q;

endmodule

// File: rtl/snn_spike_egress_packer.sv
// Multi-channel output-spike collector for the SNN datapath.
// Round-robin arbitrates spikes from NUM_CHANNELS neuron units into one
// FWFT buffer, inserts end-of-timestep marker words (tlast=1), drives an
// AXI4-Stream master and coalesces marker completions into one interrupt.
// Optional build macro: SNN_EGRESS_SPIKE_COUNT_EN puts a saturating
// per-timestep spike count into the marker low 16 bits (0 otherwise).
// Ports:
//   aclk, aresetn                 clock, asynchronous active-low reset
//   enable                        allow new spike/marker accepts
//   ch_valid, ch_nid, ch_ready    per-channel spike handshake (ready is combinational)
//   ts_end_valid, ts_end_ready    end-of-timestep request (ready is combinational)
//   m_axis_*                      stream master, tkeep constant all-ones
//   irq_threshold, irq_clear, irq marker-count interrupt
//   fifo_level, timestep          status
module snn_spike_egress_packer
  import snn_egress_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS      = 8,
  parameter int unsigned NEURON_ID_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH        = 64,
  parameter int unsigned TS_WIDTH          = 15,
  parameter int unsigned C_AXIS_DATA_WIDTH = 32
) (
  input  logic                                    aclk,
  input  logic                                    aresetn,
  input  logic                                    enable,
  input  logic [NUM_CHANNELS-1:0]                 ch_valid,
  input  logic [NUM_CHANNELS*NEURON_ID_WIDTH-1:0] ch_nid,
  output logic [NUM_CHANNELS-1:0]                 ch_ready,
  input  logic                                    ts_end_valid,
  output logic                                    ts_end_ready,
  output logic [C_AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready,
  output logic                                    m_axis_tlast,
  output logic [3:0]                              m_axis_tkeep,
  input  logic [7:0]                              irq_threshold,
  input  logic                                    irq_clear,
  output logic                                    irq,
  output logic [$clog2(FIFO_DEPTH):0]             fifo_level,
  output logic [TS_WIDTH-1:0]                     timestep
);

  localparam int unsigned RR_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned WORD_W = $bits(egress_word_t);

  logic [RR_W-1:0]            rr_q, rr_d;
  logic                       run_q;
  logic [TS_WIDTH-1:0]        timestep_q, timestep_d;
  logic [7:0]                 marker_cnt_q, marker_cnt_d;
  logic                       irq_q, irq_d;

  logic [RR_W-1:0]            lo_idx_c, hi_idx_c, gidx_c;
  logic                       lo_found_c, hi_found_c, found_c;
  logic [NUM_CHANNELS-1:0]    grant_c;
  logic [NEURON_ID_WIDTH-1:0] sel_nid_c;
  logic                       accept_ok_c;
  logic                       spike_acc_c, marker_acc_c;
  logic [LOW_FIELD_W-1:0]     marker_low_c;
  egress_word_t               push_word_c;

  egress_word_t               head_w;
  logic                       fifo_valid, fifo_full;
  logic                       marker_hs_c;
  logic [7:0]                 irq_thr_c;

  // Round-robin grant: lowest valid channel at or after rr_q, else the
  // lowest valid channel overall (wrap-around).
  always_comb begin
    lo_idx_c   = '0;
    hi_idx_c   = '0;
    lo_found_c = 1'b0;
    hi_found_c = 1'b0;
    for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
      if (ch_valid[c]) begin
        lo_idx_c   = RR_W'(c);
        lo_found_c = 1'b1;
      end
      if (ch_valid[c] && (RR_W'(c) >= rr_q)) begin
        hi_idx_c   = RR_W'(c);
        hi_found_c = 1'b1;
      end
    end
    found_c = hi_found_c || lo_found_c;
    gidx_c  = hi_found_c ? hi_idx_c : lo_idx_c;
    grant_c   = '0;
    sel_nid_c = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      grant_c[c] = found_c && (gidx_c == RR_W'(c));
      if (grant_c[c]) begin
        sel_nid_c = ch_nid[c*NEURON_ID_WIDTH +: NEURON_ID_WIDTH];
      end
    end
  end

  // Accept gating; markers wait until no channel has a pending spike.
  always_comb begin
    accept_ok_c  = run_q && enable && !fifo_full;
    ch_ready     = grant_c & {NUM_CHANNELS{accept_ok_c}};
    ts_end_ready = accept_ok_c && (ch_valid == '0);
    spike_acc_c  = found_c && accept_ok_c;
    marker_acc_c = ts_end_valid && ts_end_ready;
  end

`ifdef SNN_EGRESS_SPIKE_COUNT_EN
  logic [15:0] spk_cnt_q, spk_cnt_d;

  // Saturating spike count for the timestep currently open.
  always_comb begin
    spk_cnt_d = spk_cnt_q;
    if (marker_acc_c) begin
      spk_cnt_d = '0;
    end else if (spike_acc_c && (spk_cnt_q != 16'hFFFF)) begin
      spk_cnt_d = spk_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      spk_cnt_q <= '0;
    end else begin
      spk_cnt_q <= spk_cnt_d;
    end
  end

  assign marker_low_c = LOW_FIELD_W'(spk_cnt_q);
`else
  assign marker_low_c = '0;
`endif

  // Word to enqueue, round-robin pointer and timestep next state.
  always_comb begin
    push_word_c.tlast = marker_acc_c;
    if (marker_acc_c) begin
      push_word_c.tdata = build_marker(TS_FIELD_W'(timestep_q), marker_low_c);
    end else begin
      push_word_c.tdata = build_spike(TS_FIELD_W'(timestep_q), LOW_FIELD_W'(sel_nid_c));
    end
    rr_d = rr_q;
    if (spike_acc_c) begin
      rr_d = (gidx_c == RR_W'(NUM_CHANNELS - 1)) ? '0 : gidx_c + RR_W'(1);
    end
    timestep_d = timestep_q + TS_WIDTH'(marker_acc_c);
  end

  // Marker-completion interrupt; a clear beats a simultaneous handshake
  // but that handshake still counts as the first marker afterwards.
  always_comb begin
    irq_thr_c    = (irq_threshold == 8'd0) ? 8'd1 : irq_threshold;
    marker_hs_c  = fifo_valid && m_axis_tready && head_w.tlast;
    marker_cnt_d = marker_cnt_q;
    if (irq_clear) begin
      marker_cnt_d = marker_hs_c ? 8'd1 : 8'd0;
    end else if (marker_hs_c && (marker_cnt_q != 8'hFF)) begin
      marker_cnt_d = marker_cnt_q + 8'd1;
    end
    irq_d = irq_clear ? 1'b0 : (marker_cnt_d >= irq_thr_c);
  end

  // run_q keeps the handshakes closed while reset is asserted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run_q        <= 1'b0;
      rr_q         <= '0;
      timestep_q   <= '0;
      marker_cnt_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      run_q        <= 1'b1;
      rr_q         <= rr_d;
      timestep_q   <= timestep_d;
      marker_cnt_q <= marker_cnt_d;
      irq_q        <= irq_d;
    end
  end

  snn_egress_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .push_i  (spike_acc_c || marker_acc_c),
    .wdata_i (push_word_c),
    .pop_i   (m_axis_tready),
    .rdata_o (head_w),
    .valid_o (fifo_valid),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  assign m_axis_tdata  = C_AXIS_DATA_WIDTH'(head_w.tdata);
  assign m_axis_tvalid = fifo_valid;
  assign m_axis_tlast  = head_w.tlast;
  assign m_axis_tkeep  = TKEEP_ALL;
  assign irq           = irq_q;
  assign timestep      = timestep_q;

endmodule
